// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the MINI-RISC hazard control unit
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        BR_FLUSH = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] WM_NONE = 2'b00;

    typedef struct packed {
        logic stall_F;
        logic stall_D;
        logic stall_E;
        logic flush_F;
        logic flush_D;
        logic flush_E;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE   = 6'b000000;
    localparam ctrl_t CTRL_TRAP   = 6'b000111;
    localparam ctrl_t CTRL_MEM    = 6'b111000;
    localparam ctrl_t CTRL_BRANCH = 6'b000110;
    localparam ctrl_t CTRL_LOAD   = 6'b110010;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = 3
);
    logic [REG_ADDR_W-1:0] rs1_D;
    logic [REG_ADDR_W-1:0] rs2_D;
    logic                  uses_rs1_D;
    logic                  uses_rs2_D;
    logic [REG_ADDR_W-1:0] rs1_E;
    logic [REG_ADDR_W-1:0] rs2_E;
    logic [REG_ADDR_W-1:0] rd_E;
    logic [1:0]            write_mode_E;
    logic                  mem_read_E;
    logic [REG_ADDR_W-1:0] rd_W;
    logic [1:0]            write_mode_W;
    logic                  branch_taken_E;
    logic                  trap_E;
    logic                  mem_busy;
    logic                  stall_F;
    logic                  stall_D;
    logic                  stall_E;
    logic                  flush_F;
    logic                  flush_D;
    logic                  flush_E;
    logic [1:0]            fwd_a_E;
    logic [1:0]            fwd_b_E;
    logic [15:0]           stall_count;
    logic                  mem_timeout;

    modport master (
        output rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rs1_E, rs2_E, rd_E,
               write_mode_E, mem_read_E, rd_W, write_mode_W, branch_taken_E,
               trap_E, mem_busy,
        input  stall_F, stall_D, stall_E, flush_F, flush_D, flush_E,
               fwd_a_E, fwd_b_E, stall_count, mem_timeout
    );

    modport slave (
        input  rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rs1_E, rs2_E, rd_E,
               write_mode_E, mem_read_E, rd_W, write_mode_W, branch_taken_E,
               trap_E, mem_busy,
        output stall_F, stall_D, stall_E, flush_F, flush_D, flush_E,
               fwd_a_E, fwd_b_E, stall_count, mem_timeout
    );
endinterface

// File: rtl/hazard_control_unit_fwd_select.sv
// rtl/hazard_control_unit_fwd_select.sv - W->E forwarding select for one source operand
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [1:0]            write_mode,
    output logic [1:0]            sel
);

    assign sel = ((write_mode != WM_NONE) && (rd == rs)) ? FWD_W : FWD_REG;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush sequencing and forwarding selects for the F/D/E/W pipeline
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT         = 255,
    parameter int REG_ADDR_W          = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    hazard_control_unit_if.slave bus
);

    localparam logic [7:0] LD_INIT = 8'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] BR_INIT = 8'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d, run_state;
    logic [7:0]  cnt_q, cnt_d, run_cnt;
    logic [15:0] stall_count_q;
    logic        mem_timeout_q;
    ctrl_t       ctrl, run_ctrl;
    logic        load_use;
    logic        bubble;
    logic [1:0]  fwd_a, fwd_b;

    assign load_use = bus.mem_read_E && (bus.write_mode_E != WM_NONE) &&
                      ((bus.uses_rs1_D && (bus.rs1_D == bus.rd_E)) ||
                       (bus.uses_rs2_D && (bus.rs2_D == bus.rd_E)));

    // Response of an idle pipeline; also used on MEM_WAIT release and for preemption.
    always_comb begin
        run_ctrl  = CTRL_NONE;
        run_state = RUN;
        run_cnt   = '0;
        if (bus.trap_E) begin
            run_ctrl = CTRL_TRAP;
        end else if (bus.mem_busy) begin
            run_ctrl  = CTRL_MEM;
            run_state = MEM_WAIT;
            run_cnt   = 8'd1;
        end else if (bus.branch_taken_E) begin
            run_ctrl = CTRL_BRANCH;
            if (BRANCH_FLUSH_CYCLES > 1) begin
                run_state = BR_FLUSH;
                run_cnt   = BR_INIT;
            end
        end else if (load_use) begin
            run_ctrl = CTRL_LOAD;
            if (LOAD_STALL_CYCLES > 1) begin
                run_state = LD_STALL;
                run_cnt   = LD_INIT;
            end
        end
    end

    always_comb begin
        ctrl    = run_ctrl;
        state_d = run_state;
        cnt_d   = run_cnt;
        case (state_q)
            RUN: ;
            LD_STALL: begin
                if (!(bus.trap_E || bus.mem_busy || bus.branch_taken_E)) begin
                    ctrl = CTRL_LOAD;
                    if (cnt_q <= 8'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = LD_STALL;
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
            end
            BR_FLUSH: begin
                if (!(bus.trap_E || bus.mem_busy)) begin
                    ctrl = CTRL_BRANCH;
                    if (cnt_q <= 8'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = BR_FLUSH;
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
            end
            MEM_WAIT: begin
                // E is frozen, so branch/trap are re-seen once memory releases.
                if (bus.mem_busy) begin
                    ctrl    = CTRL_MEM;
                    state_d = MEM_WAIT;
                    cnt_d   = sat_inc8(cnt_q);
                end
            end
            default: ;
        endcase
    end

    assign bubble = ctrl.stall_F | ctrl.stall_D | ctrl.stall_E | ctrl.flush_D;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bubble && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
            if ((state_d == MEM_WAIT) && (cnt_d >= TIMEOUT)) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs         (bus.rs1_E),
        .rd         (bus.rd_W),
        .write_mode (bus.write_mode_W),
        .sel        (fwd_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs         (bus.rs2_E),
        .rd         (bus.rd_W),
        .write_mode (bus.write_mode_W),
        .sel        (fwd_b)
    );

    assign bus.stall_F     = reset_n & ctrl.stall_F;
    assign bus.stall_D     = reset_n & ctrl.stall_D;
    assign bus.stall_E     = reset_n & ctrl.stall_E;
    assign bus.flush_F     = ~reset_n | ctrl.flush_F;
    assign bus.flush_D     = ~reset_n | ctrl.flush_D;
    assign bus.flush_E     = ~reset_n | ctrl.flush_E;
    assign bus.fwd_a_E     = reset_n ? fwd_a : FWD_REG;
    assign bus.fwd_b_E     = reset_n ? fwd_b : FWD_REG;
    assign bus.stall_count = stall_count_q;
    assign bus.mem_timeout = mem_timeout_q;

endmodule
